// File: rtl/manchester_pkg.sv
// Shared constants and types for the Manchester receive framer.
// The preamble and start-word patterns are also used by the TX preamble inserter.
package manchester_pkg;

  localparam logic [7:0] PREAMBLE_PATTERN = 8'hAA;
  localparam logic [7:0] START_WORD       = 8'hD5;

  // The preamble counter saturates at this value.
  localparam logic [3:0] PRE_CNT_MAX = 4'd15;

  typedef enum logic [1:0] {
    StHunt,
    StPre,
    StPayload,
    StDrain
  } rx_state_e;

  localparam logic [1:0] ERR_NONE           = 2'b00;
  localparam logic [1:0] ERR_BAD_PREAMBLE   = 2'b01;
  localparam logic [1:0] ERR_SHORT_PREAMBLE = 2'b10;
  localparam logic [1:0] ERR_EARLY_LAST     = 2'b11;

endpackage

// File: rtl/axis_pipe_reg.sv
// One-deep AXI-Stream register slice carrying data and last.
// Ports:
//   aclk, aresetn       clock, asynchronous active-low reset
//   s_valid_i/s_ready_o upstream handshake, s_data_i/s_last_i upstream payload
//   m_valid_o/m_ready_i downstream handshake, m_data_o/m_last_o registered payload
// Accepts a new beat whenever the register is empty or is being drained in the
// same cycle, giving full throughput with one cycle of latency.
module axis_pipe_reg #(
  parameter int unsigned DataWidth = 8
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic [DataWidth-1:0] s_data_i,
  input  logic                 s_last_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [DataWidth-1:0] m_data_o,
  output logic                 m_last_o
);

  logic                 valid_q, valid_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic                 last_q, last_d;
  logic                 load;

  assign s_ready_o = !valid_q || m_ready_i;
  assign load      = s_valid_i && s_ready_o;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = s_data_i;
      last_d  = s_last_i;
    end else if (m_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;
  assign m_last_o  = last_q;

endmodule

// File: rtl/manchester_preamble_strip.sv
// Receive-side framer behind the Manchester decoder byte stream.
// Hunts for AA preamble bytes followed by a D5 start word, then forwards only the
// payload bytes (with tlast) as an AXI-Stream frame. Malformed frames are dropped
// and counted.
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   s_axis_*               decoded byte stream in (tdata, tvalid, tready, tlast)
//   m_axis_*               payload stream out (tdata, tvalid, tready, tlast)
//   frame_ok_cnt           frames delivered (wraps)
//   frame_err_cnt          frames dropped (wraps)
//   err_pulse              one-cycle pulse per dropped frame
//   err_code               cause of the most recent drop, held until the next one
module manchester_preamble_strip
  import manchester_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned MIN_PREAMBLE = 1,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [CNT_WIDTH-1:0]  frame_ok_cnt,
  output logic [CNT_WIDTH-1:0]  frame_err_cnt,
  output logic                  err_pulse,
  output logic [1:0]            err_code
);

  if (DATA_WIDTH != 8) begin : gen_width_check
    $error("manchester_preamble_strip supports DATA_WIDTH = 8 only");
  end
  if (MIN_PREAMBLE > 15) begin : gen_min_pre_check
    $error("MIN_PREAMBLE must not exceed the saturating preamble count of 15");
  end

  localparam logic [3:0] MinPre = 4'(MIN_PREAMBLE);

  rx_state_e            state_q, state_d;
  logic [3:0]           pre_cnt_q, pre_cnt_d;
  logic [CNT_WIDTH-1:0] ok_cnt_q, ok_cnt_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                 err_pulse_q, err_pulse_d;
  logic [1:0]           err_code_q, err_code_d;
  // Holds tready low while in reset and for the first edge after release.
  logic                 run_q;

  logic                 pipe_ready;
  logic                 pipe_valid;
  logic                 in_beat;
  logic                 is_pre;
  logic                 is_start;
  logic                 raise_err;
  logic [1:0]           new_code;

  assign s_axis_tready = run_q && ((state_q == StPayload) ? pipe_ready : 1'b1);
  assign in_beat       = s_axis_tvalid && s_axis_tready;
  assign pipe_valid    = s_axis_tvalid && run_q && (state_q == StPayload);
  assign is_pre        = (s_axis_tdata == PREAMBLE_PATTERN);
  assign is_start      = (s_axis_tdata == START_WORD);

  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    ok_cnt_d    = ok_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_code_d  = err_code_q;
    err_pulse_d = 1'b0;
    raise_err   = 1'b0;
    new_code    = ERR_NONE;

    if (in_beat) begin
      unique case (state_q)
        StHunt: begin
          if (is_pre && !s_axis_tlast) begin
            state_d   = StPre;
            pre_cnt_d = 4'd1;
          end
        end
        StPre: begin
          if (is_pre) begin
            if (s_axis_tlast) begin
              raise_err = 1'b1;
              new_code  = ERR_EARLY_LAST;
              state_d   = StHunt;
            end else if (pre_cnt_q != PRE_CNT_MAX) begin
              pre_cnt_d = pre_cnt_q + 4'd1;
            end
          end else if (is_start) begin
            if (pre_cnt_q < MinPre) begin
              raise_err = 1'b1;
              new_code  = ERR_SHORT_PREAMBLE;
              state_d   = s_axis_tlast ? StHunt : StDrain;
            end else if (s_axis_tlast) begin
              raise_err = 1'b1;
              new_code  = ERR_EARLY_LAST;
              state_d   = StHunt;
            end else begin
              state_d = StPayload;
            end
          end else begin
            raise_err = 1'b1;
            new_code  = ERR_BAD_PREAMBLE;
            state_d   = s_axis_tlast ? StHunt : StDrain;
          end
        end
        StPayload: begin
          if (s_axis_tlast) begin
            ok_cnt_d = ok_cnt_q + CNT_WIDTH'(1);
            state_d  = StHunt;
          end
        end
        StDrain: begin
          if (s_axis_tlast) begin
            state_d = StHunt;
          end
        end
        default: state_d = StHunt;
      endcase
    end

    if (raise_err) begin
      err_pulse_d = 1'b1;
      err_cnt_d   = err_cnt_q + CNT_WIDTH'(1);
      err_code_d  = new_code;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= StHunt;
      pre_cnt_q   <= 4'd0;
      ok_cnt_q    <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      ok_cnt_q    <= ok_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
      run_q       <= 1'b1;
    end
  end

  axis_pipe_reg #(
    .DataWidth(DATA_WIDTH)
  ) u_out_reg (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .s_valid_i(pipe_valid),
    .s_ready_o(pipe_ready),
    .s_data_i (s_axis_tdata),
    .s_last_i (s_axis_tlast),
    .m_valid_o(m_axis_tvalid),
    .m_ready_i(m_axis_tready),
    .m_data_o (m_axis_tdata),
    .m_last_o (m_axis_tlast)
  );

  assign frame_ok_cnt  = ok_cnt_q;
  assign frame_err_cnt = err_cnt_q;
  assign err_pulse     = err_pulse_q;
  assign err_code      = err_code_q;

endmodule
